// File: rtl/clkdiv_ctrl.sv
// ============================================================================
// clkdiv_ctrl : run-time programmable clock divider with glitch-free retune
// Rev 1.0
// ============================================================================
`default_nettype none

module clkdiv_ctrl #(
    parameter int               CNT_W       = 16,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(2)
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             en,
    input  logic             div_valid,
    input  logic [CNT_W-1:0] div_data,
    output logic             div_ready,
    output logic             clkout,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] cur_div,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Even ratios only, minimum 2, so both phases are at least one cycle.
    function automatic logic [CNT_W-1:0] sanitize(input logic [CNT_W-1:0] d);
        logic [CNT_W-1:0] v;
        v = {d[CNT_W-1:1], 1'b0};
        if (v < CNT_W'(2)) begin
            v = CNT_W'(2);
        end
        return v;
    endfunction

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             clkout_q;
    logic             rise_q;
    logic             fall_q;
    logic [CNT_W-1:0] cur_div_q;
    logic [CNT_W-1:0] pend_q;
    logic             pend_full_q;

    logic [CNT_W-1:0] pend_d;
    logic [CNT_W-1:0] half;
    logic             phase_done;
    logic             xfer;

    assign pend_d     = sanitize(div_data);
    assign half       = cur_div_q >> 1;
    assign phase_done = (cnt_q == (half - CNT_W'(1)));
    assign xfer       = div_valid && !pend_full_q;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ST_STOP;
            cnt_q       <= '0;
            clkout_q    <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            cur_div_q   <= sanitize(DEFAULT_DIV);
            pend_q      <= '0;
            pend_full_q <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;

            // A transfer needs an empty slot, so it never coincides with an apply.
            if (xfer) begin
                pend_q      <= pend_d;
                pend_full_q <= 1'b1;
            end

            case (state_q)
                ST_STOP: begin
                    cnt_q    <= '0;
                    clkout_q <= 1'b0;
                    if (pend_full_q) begin
                        cur_div_q   <= pend_q;
                        pend_full_q <= 1'b0;
                    end
                    if (en) begin
                        state_q <= ST_RUN;
                    end
                end

                ST_RUN, ST_DRAIN: begin
                    if (!en && !clkout_q) begin
                        state_q <= ST_STOP;
                        cnt_q   <= '0;
                    end else if (!phase_done) begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        state_q <= en ? ST_RUN : ST_DRAIN;
                    end else begin
                        cnt_q    <= '0;
                        clkout_q <= !clkout_q;
                        if (clkout_q) begin
                            // Falling edge: the only safe point to retune or stop.
                            fall_q <= 1'b1;
                            if (pend_full_q) begin
                                cur_div_q   <= pend_q;
                                pend_full_q <= 1'b0;
                            end
                            state_q <= en ? ST_RUN : ST_STOP;
                        end else begin
                            rise_q  <= 1'b1;
                            state_q <= ST_RUN;
                        end
                    end
                end

                default: begin
                    state_q  <= ST_STOP;
                    cnt_q    <= '0;
                    clkout_q <= 1'b0;
                end
            endcase
        end
    end

    assign div_ready = !pend_full_q;
    assign clkout    = clkout_q;
    assign rise_tick = rise_q;
    assign fall_tick = fall_q;
    assign cur_div   = cur_div_q;
    assign busy      = (state_q != ST_STOP);

endmodule

`default_nettype wire

// File: tb/tb_clkdiv_ctrl.sv
// ============================================================================
// tb_clkdiv_ctrl : randomized bench against a phase-level divider model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_clkdiv_ctrl;

    localparam int CNT_W = 16;

    logic             clk;
    logic             nRST;
    logic             en;
    logic             div_valid;
    logic [CNT_W-1:0] div_data;
    logic             div_ready;
    logic             clkout;
    logic             rise_tick;
    logic             fall_tick;
    logic [CNT_W-1:0] cur_div;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    // Model state: output level, cycles left in the current phase, active flag.
    bit          m_active;
    bit          m_level;
    int unsigned m_left;
    int unsigned m_cur;
    int unsigned m_pend;
    bit          m_pvalid;
    bit          m_rise;
    bit          m_fall;

    clkdiv_ctrl #(
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(16'd2)
    ) dut (
        .clk      (clk),
        .nRST     (nRST),
        .en       (en),
        .div_valid(div_valid),
        .div_data (div_data),
        .div_ready(div_ready),
        .clkout   (clkout),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick),
        .cur_div  (cur_div),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned san(input int unsigned d);
        int unsigned v;
        v = (d / 2) * 2;
        return (v < 2) ? 2 : v;
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_level  = 0;
        m_left   = 0;
        m_cur    = san(2);
        m_pend   = 0;
        m_pvalid = 0;
        m_rise   = 0;
        m_fall   = 0;
    endtask

    task automatic model_step(input bit en_v, input bit vld, input int unsigned data);
        bit xfer;
        xfer   = vld && !m_pvalid;
        m_rise = 0;
        m_fall = 0;
        if (!m_active) begin
            if (m_pvalid) begin
                m_cur    = m_pend;
                m_pvalid = 0;
            end
            if (en_v) begin
                m_active = 1;
                m_level  = 0;
                m_left   = m_cur / 2;
            end
        end else if (!en_v && !m_level) begin
            m_active = 0;
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                if (!m_level) begin
                    m_level = 1;
                    m_rise  = 1;
                    m_left  = m_cur / 2;
                end else begin
                    m_level = 0;
                    m_fall  = 1;
                    if (m_pvalid) begin
                        m_cur    = m_pend;
                        m_pvalid = 0;
                    end
                    m_left = m_cur / 2;
                    if (!en_v) m_active = 0;
                end
            end
        end
        if (xfer) begin
            m_pend   = san(data);
            m_pvalid = 1;
        end
    endtask

    task automatic check_all(input string pfx);
        chk({pfx, ".clkout"}, clkout, m_level);
        chk({pfx, ".rise"}, rise_tick, m_rise);
        chk({pfx, ".fall"}, fall_tick, m_fall);
        chk({pfx, ".cur_div"}, cur_div, m_cur);
        chk({pfx, ".busy"}, busy, m_active);
        chk({pfx, ".ready"}, div_ready, !m_pvalid);
    endtask

    initial begin
        bit          vld;
        int unsigned data;
        nRST      = 1'b0;
        en        = 1'b0;
        div_valid = 1'b0;
        div_data  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        nRST = 1'b1;

        for (int cyc = 0; cyc < 8000; cyc++) begin
            @(negedge clk);
            check_all("run");

            if ($urandom_range(0, 249) == 0) begin
                #1;
                nRST = 1'b0;
                #1;
                model_reset();
                check_all("async_rst");
                @(negedge clk);
                nRST = 1'b1;
            end

            // en is held for long stretches so full periods and drains occur.
            if (cyc < 40) en = 1'b1;
            else if ($urandom_range(0, 13) == 0) en = ~en;

            vld = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) data = $urandom_range(0, 3);
            else data = $urandom_range(0, 20);
            if ($urandom_range(0, 40) == 0) data = data | 32'h0001_0000 | (32'($urandom_range(0, 255)) << 8);
            div_valid = vld;
            div_data  = data[CNT_W-1:0];
            model_step(en, vld, int'(data[CNT_W-1:0]));
        end

        @(negedge clk);
        check_all("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/clkdiv_ctrl.md
Name: clkdiv_ctrl

Overview:
Run-time programmable clock-divider controller for LED blink and slow-strobe generation. It owns the divide ratio and start/stop sequencing. Ratio changes and stops happen only at period boundaries, so clkout never produces a runt pulse. It also emits single-cycle rise/fall strobes for logic that stays synchronous to clk.

Parameters:
CNT_W, 16, width of the divide ratio and of the internal half-period counter.
DEFAULT_DIV, 16'd2, divide ratio loaded at reset (sanitized by the same rule as div_data).

Ports:
clk  input  1  system clock
nRST  input  1  asynchronous active-low reset
en  input  1  run request; level-sensitive
div_valid  input  1  new ratio offered
div_data  input  CNT_W  requested ratio (clkout period in clk cycles)
div_ready  output  1  controller can accept a ratio
clkout  output  1  divided clock, registered, 50% duty
rise_tick  output  1  high for the first clk cycle in which clkout==1
fall_tick  output  1  high for the first clk cycle in which clkout==0 after a high phase
cur_div  output  CNT_W  ratio currently in effect
busy  output  1  state != STOP

Behaviour:
- Reset is nRST, asynchronous, active-low; the clock is clk. All state is on posedge clk / negedge nRST.
- Reset values:
  - state=STOP, cnt=0, clkout=0, rise_tick=0, fall_tick=0.
  - cur_div=sanitize(DEFAULT_DIV), pending empty, div_ready=1, busy=0.
- Sanitize rule: force LSB to 0; any result below 2 becomes 2. half = cur_div>>1.
- Ratio handshake:
  - Transfer occurs when div_valid && div_ready. The sanitized value is loaded into a pending register.
  - div_ready = !pending_full.
  - div_data is ignored when no transfer occurs.
- Applying a pending ratio:
  - STOP: applied on the edge after the transfer. cur_div <= pending, pending cleared, so div_ready is low for exactly 1 cycle.
  - RUN/DRAIN: applied on the same edge that toggles clkout 1->0. The following low phase and all later phases use the new half.
  - A transfer on the same edge as a falling toggle is not applied at that toggle; it waits for the next falling toggle.
- Counting in RUN/DRAIN:
  - If cnt < half-1, then cnt <= cnt+1.
  - Otherwise cnt <= 0 and clkout toggles.
  - Each phase lasts half cycles; the period is cur_div cycles.
- Ticks: rise_tick/fall_tick are registered alongside the toggle (set on the toggling edge, cleared on the next edge). Never both high.
- State machine STOP / RUN / DRAIN:
  - STOP, en=1 -> RUN with cnt=0 and clkout=0. If en is sampled high at edge k, clkout rises at edge k+half.
  - RUN, en=0, clkout=0 -> STOP next edge with cnt=0. No fall_tick is issued.
  - RUN, en=0, clkout=1 -> DRAIN. Counting continues until the high phase completes: clkout falls, fall_tick pulses, pending is applied, and the state becomes STOP on that same edge.
  - DRAIN, en=1 -> RUN. Counting is uninterrupted and the waveform is unchanged.
- clkout is low whenever the state is STOP. clkout never shows a high or low phase shorter than the half value in effect at that phase's start.
- Mid-operation reset: all outputs return immediately to their reset values, and pending is discarded.

Test Plan:
- Reset, DEFAULT_DIV=2, en=1 held -> clkout toggles every clk edge (period 2). rise_tick is high on every rising-phase cycle. cur_div=2, busy=1.
- STOP, transfer div_data=10, en=1 two cycles later -> div_ready low for 1 cycle; cur_div=10. First rise occurs 5 edges after en is sampled; then 5 high, 5 low, repeating.
- Running at div=10, transfer div_data=4 mid high phase -> the current high phase completes at 5 cycles. Falling edge applies cur_div=4; following phases are 2 cycles. div_ready is low from transfer to that falling edge.
- div_data=7, then 1, then 0 -> cur_div becomes 6, 2, 2 respectively.
- Running div=8, en dropped 1 cycle into the high phase -> clkout stays high 3 more cycles, then falls with fall_tick and busy=0. en dropped during the low phase -> busy=0 next edge, no fall_tick.
- Running div=8 in DRAIN, en reasserted -> waveform is identical to never dropping en. nRST pulsed mid high phase -> clkout=0, cur_div=DEFAULT_DIV, and pending is cleared immediately.
